// File: rtl/pipe_adder_tree_if.sv
// Sample-set bus for pipe_adder_tree: packed input words with valid and
// advance enable, and the registered sum with its valid and clamp flag.
interface pipe_adder_tree_if #(
    parameter int unsigned WIDTH    = 25,
    parameter int unsigned N_WORDS  = 4,
    parameter int unsigned SATURATE = 0
);
    localparam int unsigned LOG2N = $clog2(N_WORDS);
    localparam int unsigned OUT_W = (SATURATE != 0) ? WIDTH : WIDTH + LOG2N;

    logic                     CE;
    logic                     IN_VALID;
    logic [N_WORDS*WIDTH-1:0] WORDS;
    logic signed [OUT_W-1:0]  RES;
    logic                     OUT_VALID;
    logic                     OVF;

    modport master (output CE, IN_VALID, WORDS, input  RES, OUT_VALID, OVF);
    modport slave  (input  CE, IN_VALID, WORDS, output RES, OUT_VALID, OVF);
endinterface

// File: rtl/pipe_adder_tree.sv
// Pipelined binary adder tree: LOG2N registered stages summing N_WORDS signed
// words, with an optional clamp of the final sum back to WIDTH bits.
module pipe_adder_tree #(
    parameter int unsigned WIDTH    = 25,
    parameter int unsigned N_WORDS  = 4,
    parameter int unsigned SATURATE = 0
) (
    input  logic             CLK,
    input  logic             RST,
    pipe_adder_tree_if.slave io
);
    localparam int unsigned LOG2N = $clog2(N_WORDS);
    localparam int unsigned OUT_W = (SATURATE != 0) ? WIDTH : WIDTH + LOG2N;
    localparam int unsigned FW    = WIDTH + LOG2N;

    if (N_WORDS != 2 && N_WORDS != 4 && N_WORDS != 8 && N_WORDS != 16) begin : g_bad_n
        $error("pipe_adder_tree: N_WORDS must be 2, 4, 8 or 16");
    end

    // Every level is exposed at full width FW; stage k keeps only WIDTH+k bits
    // in its registers and is sign-extended here for the next level.
    logic signed [FW-1:0]    lvl [LOG2N][N_WORDS];
    logic signed [FW-1:0]    fsum;
    logic signed [OUT_W-1:0] res_d;
    logic signed [OUT_W-1:0] res_q;
    logic                    ovf_d;
    logic                    ovf_q;
    logic [LOG2N:1]          vld;

    for (genvar i = 0; i < N_WORDS; i++) begin : g_word
        assign lvl[0][i] = FW'($signed(io.WORDS[i*WIDTH +: WIDTH]));
    end

    for (genvar k = 1; k < LOG2N; k++) begin : g_stage
        localparam int unsigned NS = N_WORDS >> k;
        localparam int unsigned SW = WIDTH + k;
        for (genvar j = 0; j < N_WORDS; j++) begin : g_node
            if (j < NS) begin : g_add
                logic signed [SW-1:0] q;
                always_ff @(posedge CLK or posedge RST) begin
                    if (RST) begin
                        q <= '0;
                    end else if (io.CE) begin
                        q <= lvl[k-1][2*j][SW-1:0] + lvl[k-1][2*j+1][SW-1:0];
                    end
                end
                assign lvl[k][j] = FW'(q);
            end else begin : g_pad
                assign lvl[k][j] = '0;
            end
        end
    end

    // Final stage adds the last pair combinationally so the clamp sits ahead of
    // the output register.
    assign fsum = lvl[LOG2N-1][0] + lvl[LOG2N-1][1];

    if (SATURATE != 0) begin : g_sat
        localparam logic signed [FW-1:0] MAXV = {{(LOG2N+1){1'b0}}, {(WIDTH-1){1'b1}}};
        localparam logic signed [FW-1:0] MINV = {{(LOG2N+1){1'b1}}, {(WIDTH-1){1'b0}}};
        always_comb begin
            res_d = fsum[OUT_W-1:0];
            ovf_d = 1'b0;
            if (fsum > MAXV) begin
                res_d = MAXV[OUT_W-1:0];
                ovf_d = 1'b1;
            end else if (fsum < MINV) begin
                res_d = MINV[OUT_W-1:0];
                ovf_d = 1'b1;
            end
        end
    end else begin : g_full
        always_comb begin
            res_d = fsum;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld   <= '0;
            res_q <= '0;
            ovf_q <= 1'b0;
        end else if (io.CE) begin
            vld[1] <= io.IN_VALID;
            for (int unsigned k = 2; k <= LOG2N; k++) begin
                vld[k] <= vld[k-1];
            end
            res_q <= res_d;
            ovf_q <= ovf_d;
        end
    end

    assign io.RES       = res_q;
    assign io.OUT_VALID = vld[LOG2N];
    assign io.OVF       = ovf_q;
endmodule

// File: tb/tb_pipe_adder_tree.sv
// Bench for pipe_adder_tree: four configurations driven in parallel and
// compared against a queue-based model of sums and CE-cycle latencies.
module tb_pipe_adder_tree;
    localparam int unsigned W    = 25;
    localparam longint      MAXS = 16777215;
    localparam longint      MINS = -16777216;

    logic            clk = 1'b0;
    logic            rst;
    logic            ce;
    logic            in_valid;
    logic [4*W-1:0]  words4;
    logic [8*W-1:0]  words8;
    logic [16*W-1:0] words16;

    pipe_adder_tree_if #(.WIDTH(W), .N_WORDS(4),  .SATURATE(0)) if_def ();
    pipe_adder_tree_if #(.WIDTH(W), .N_WORDS(4),  .SATURATE(1)) if_sat ();
    pipe_adder_tree_if #(.WIDTH(W), .N_WORDS(8),  .SATURATE(0)) if_n8  ();
    pipe_adder_tree_if #(.WIDTH(W), .N_WORDS(16), .SATURATE(0)) if_n16 ();

    assign if_def.CE = ce;  assign if_def.IN_VALID = in_valid;  assign if_def.WORDS = words4;
    assign if_sat.CE = ce;  assign if_sat.IN_VALID = in_valid;  assign if_sat.WORDS = words4;
    assign if_n8.CE  = ce;  assign if_n8.IN_VALID  = in_valid;  assign if_n8.WORDS  = words8;
    assign if_n16.CE = ce;  assign if_n16.IN_VALID = in_valid;  assign if_n16.WORDS = words16;

    pipe_adder_tree #(.WIDTH(W), .N_WORDS(4),  .SATURATE(0)) u_def (.CLK(clk), .RST(rst), .io(if_def));
    pipe_adder_tree #(.WIDTH(W), .N_WORDS(4),  .SATURATE(1)) u_sat (.CLK(clk), .RST(rst), .io(if_sat));
    pipe_adder_tree #(.WIDTH(W), .N_WORDS(8),  .SATURATE(0)) u_n8  (.CLK(clk), .RST(rst), .io(if_n8));
    pipe_adder_tree #(.WIDTH(W), .N_WORDS(16), .SATURATE(0)) u_n16 (.CLK(clk), .RST(rst), .io(if_n16));

    always #5 clk = ~clk;

    typedef struct {
        longint      res;
        bit          ovf;
        int unsigned at;
    } exp_t;

    typedef struct {
        int     w0, w1, w2, w3;
        longint e_full;
        longint e_sat;
        bit     e_ovf;
    } vec_t;

    exp_t        sbq [4][$];
    int unsigned lg [4] = '{2, 2, 3, 4};
    int unsigned ce_cnt;
    int unsigned pops [4];
    int unsigned vseen [4];
    bit          last_ce;
    longint      ares [4];
    bit          av [4];
    bit          ao [4];
    longint      snap_res [4];
    bit          snap_v [4];
    bit          snap_o [4];
    int          n_checks = 0;
    int          n_pass   = 0;
    vec_t        tbl [8];

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    function automatic longint sum_words(input logic [16*W-1:0] w, input int n);
        longint              s;
        logic signed [W-1:0] t;
        s = 0;
        for (int i = 0; i < n; i++) begin
            t = w[i*W +: W];
            s += t;
        end
        return s;
    endfunction

    function automatic exp_t mk(input longint s, input bit sat, input int unsigned at);
        exp_t e;
        e.res = s;
        e.ovf = 1'b0;
        e.at  = at;
        if (sat && s > MAXS) begin
            e.res = MAXS;
            e.ovf = 1'b1;
        end else if (sat && s < MINS) begin
            e.res = MINS;
            e.ovf = 1'b1;
        end
        return e;
    endfunction

    // Reference model: every accepted set is queued with the CE-cycle index it entered at.
    always @(posedge clk or posedge rst) begin
        logic [16*W-1:0] w4x;
        logic [16*W-1:0] w8x;
        if (rst) begin
            for (int d = 0; d < 4; d++) sbq[d].delete();
            ce_cnt  = 0;
            last_ce = 1'b0;
        end else begin
            last_ce = ce;
            if (ce) begin
                if (in_valid) begin
                    w4x = '0;
                    w4x[4*W-1:0] = words4;
                    w8x = '0;
                    w8x[8*W-1:0] = words8;
                    sbq[0].push_back(mk(sum_words(w4x, 4), 1'b0, ce_cnt));
                    sbq[1].push_back(mk(sum_words(w4x, 4), 1'b1, ce_cnt));
                    sbq[2].push_back(mk(sum_words(w8x, 8), 1'b0, ce_cnt));
                    sbq[3].push_back(mk(sum_words(words16, 16), 1'b0, ce_cnt));
                end
                ce_cnt++;
            end
        end
    end

    task automatic score(input int d);
        exp_t e;
        bit   due;
        due = (sbq[d].size() != 0) && (ce_cnt - sbq[d][0].at >= lg[d]);
        chk($sformatf("dut%0d OUT_VALID", d), av[d], due);
        if (av[d]) begin
            vseen[d]++;
            if (sbq[d].size() != 0) begin
                e = sbq[d].pop_front();
                pops[d]++;
                chk($sformatf("dut%0d RES", d), ares[d], e.res);
                chk($sformatf("dut%0d OVF", d), ao[d], e.ovf);
                chk($sformatf("dut%0d latency", d), ce_cnt - e.at, lg[d]);
            end
        end
    endtask

    always @(negedge clk) begin
        ares[0] = if_def.RES;  av[0] = if_def.OUT_VALID;  ao[0] = if_def.OVF;
        ares[1] = if_sat.RES;  av[1] = if_sat.OUT_VALID;  ao[1] = if_sat.OVF;
        ares[2] = if_n8.RES;   av[2] = if_n8.OUT_VALID;   ao[2] = if_n8.OVF;
        ares[3] = if_n16.RES;  av[3] = if_n16.OUT_VALID;  ao[3] = if_n16.OVF;
        for (int d = 0; d < 4; d++) begin
            if (rst) begin
                chk($sformatf("dut%0d reset RES", d), ares[d], 0);
                chk($sformatf("dut%0d reset OUT_VALID", d), av[d], 0);
            end else if (last_ce) begin
                score(d);
            end else begin
                chk($sformatf("dut%0d stall RES", d), ares[d], snap_res[d]);
                chk($sformatf("dut%0d stall OUT_VALID", d), av[d], snap_v[d]);
                chk($sformatf("dut%0d stall OVF", d), ao[d], snap_o[d]);
            end
            snap_res[d] = ares[d];
            snap_v[d]   = av[d];
            snap_o[d]   = ao[d];
        end
    end

    task automatic set4(input int a, input int b, input int c, input int d);
        words4[0*W +: W] = W'(a);
        words4[1*W +: W] = W'(b);
        words4[2*W +: W] = W'(c);
        words4[3*W +: W] = W'(d);
    endtask

    task automatic rand_words();
        int unsigned mode;
        mode = $urandom_range(0, 5);
        for (int i = 0; i < 4; i++) begin
            if (mode == 0)      words4[i*W +: W] = W'(MAXS);
            else if (mode == 1) words4[i*W +: W] = W'(MINS);
            else                words4[i*W +: W] = W'($urandom);
        end
        for (int i = 0; i < 8; i++)  words8[i*W +: W]  = W'($urandom);
        for (int i = 0; i < 16; i++) words16[i*W +: W] = W'($urandom);
    endtask

    initial begin
        int unsigned p0;
        int unsigned vs2;
        int unsigned vs3;

        tbl[0] = '{1, 2, -3, 4, 4, 4, 1'b0};
        tbl[1] = '{16777215, 16777215, 16777215, 16777215, 67108860, MAXS, 1'b1};
        tbl[2] = '{-16777216, -16777216, -16777216, -16777216, -67108864, MINS, 1'b1};
        tbl[3] = '{1, 3, -5, 10, 9, 9, 1'b0};
        tbl[4] = '{16777215, 0, 0, 0, 16777215, MAXS, 1'b0};
        tbl[5] = '{16777215, 1, 0, 0, 16777216, MAXS, 1'b1};
        tbl[6] = '{-16777216, 0, 0, 0, -16777216, MINS, 1'b0};
        tbl[7] = '{-16777216, -1, 0, 0, -16777217, MINS, 1'b1};

        rst = 1'b1; ce = 1'b0; in_valid = 1'b0;
        words4 = '0; words8 = '0; words16 = '0;
        #6;
        chk("initial def RES", if_def.RES, 0);
        chk("initial def OUT_VALID", if_def.OUT_VALID, 0);
        chk("initial sat OVF", if_sat.OVF, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            set4(tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].w3);
            in_valid = 1'b1; ce = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            #1;
            chk($sformatf("tbl%0d def OUT_VALID", i), if_def.OUT_VALID, 1);
            chk($sformatf("tbl%0d def RES", i), if_def.RES, tbl[i].e_full);
            chk($sformatf("tbl%0d def OVF", i), if_def.OVF, 0);
            chk($sformatf("tbl%0d sat RES", i), if_sat.RES, tbl[i].e_sat);
            chk($sformatf("tbl%0d sat OVF", i), if_sat.OVF, tbl[i].e_ovf);
        end

        // Five back-to-back sets with a three-cycle stall after the second.
        p0 = pops[0];
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                ce = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    rand_words(); in_valid = 1'b1;
                    @(negedge clk);
                end
                ce = 1'b1;
            end
            rand_words(); in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("stream result count", pops[0] - p0, 5);

        for (int i = 0; i < 8; i++)  words8[i*W +: W]  = W'(i + 1);
        for (int i = 0; i < 16; i++) words16[i*W +: W] = W'(i + 1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("n8 ramp OUT_VALID", if_n8.OUT_VALID, 1);
        chk("n8 ramp RES", if_n8.RES, 36);
        @(negedge clk);
        #1;
        chk("n16 ramp OUT_VALID", if_n16.OUT_VALID, 1);
        chk("n16 ramp RES", if_n16.RES, 136);
        repeat (2) @(negedge clk);

        // Two sets in flight, then an asynchronous reset between edges.
        vs2 = vseen[2];
        vs3 = vseen[3];
        rand_words(); in_valid = 1'b1;
        @(negedge clk);
        rand_words();
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async rst def RES", if_def.RES, 0);
        chk("async rst def OUT_VALID", if_def.OUT_VALID, 0);
        chk("async rst n8 RES", if_n8.RES, 0);
        chk("async rst n16 OUT_VALID", if_n16.OUT_VALID, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk("n8 flushed sets", vseen[2] - vs2, 0);
        chk("n16 flushed sets", vseen[3] - vs3, 0);

        for (int c = 0; c < 400; c++) begin
            rand_words();
            in_valid = ($urandom_range(0, 3) != 0);
            ce       = ($urandom_range(0, 4) != 0);
            @(negedge clk);
        end
        ce = 1'b1; in_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        for (int d = 0; d < 4; d++) chk($sformatf("dut%0d drained", d), sbq[d].size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipe_adder_tree.md
PIPE_ADDER_TREE -- requirements
Module: pipe_adder_tree

Interface
REQ-001 SHALL have parameter WIDTH, default 25: signed two's-complement width of each input word.
REQ-002 SHALL have parameter N_WORDS, default 4: number of input words; legal values 2, 4, 8, 16; any other value SHALL fail elaboration.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = full-precision output, 1 = output clamped to WIDTH bits.
REQ-004 SHALL define derived constants LOG2N = log2(N_WORDS) and OUT_W = SATURATE ? WIDTH : WIDTH+LOG2N.
REQ-005 SHALL have port CLK, input, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port RST, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port CE, input, 1: pipeline advance enable.
REQ-008 SHALL have port IN_VALID, input, 1: WORDS holds a valid sample set this cycle.
REQ-009 SHALL have port WORDS, input, N_WORDS*WIDTH: packed signed words; word i occupies bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port RES, output, OUT_W: signed sum of one sample set.
REQ-011 SHALL have port OUT_VALID, output, 1: RES and OVF are valid this cycle.
REQ-012 SHALL have port OVF, output, 1: the sum aligned with RES was clamped.

Function
REQ-013 SHALL form a binary adder tree of LOG2N registered stages; stage k (1..LOG2N) holds N_WORDS/2^k partial sums of width WIDTH+k.
REQ-014 Stage 1 SHALL add word pairs (0,1), (2,3), ...; stage k SHALL add adjacent pairs from stage k-1; all additions sign-extended, no truncation.
REQ-015 Latency SHALL be exactly LOG2N CE-enabled cycles from IN_VALID/WORDS sampling to OUT_VALID/RES (N_WORDS=4: 2 cycles).
REQ-016 Throughput SHALL be one sample set per CE-enabled cycle, with no bubbles between consecutive valid sets.
REQ-017 A valid bit SHALL travel with each stage; OUT_VALID SHALL equal the valid bit of the final stage.
REQ-018 Stage registers SHALL load regardless of the valid bit; RES SHALL be meaningful only while OUT_VALID=1.
REQ-019 While CE=0, all stage registers, valid bits, RES, OUT_VALID and OVF SHALL hold their values, and WORDS/IN_VALID SHALL be ignored.
REQ-020 With SATURATE=0, RES SHALL be the exact full-precision sum and OVF SHALL be constant 0.
REQ-021 With SATURATE=1, the final-stage sum SHALL be clamped before registering: above 2^(WIDTH-1)-1 gives 2^(WIDTH-1)-1, below -2^(WIDTH-1) gives -2^(WIDTH-1), otherwise unchanged.
REQ-022 With SATURATE=1, OVF SHALL be registered with RES and be 1 exactly when clamping occurred.
REQ-023 Intermediate stages SHALL NOT saturate; clamping applies only to the final sum.
REQ-024 There SHALL be no combinational path from any input to any output.

Reset
REQ-025 While RST=1, all stage registers, all valid bits, RES, OUT_VALID and OVF SHALL be 0, asynchronously and regardless of CLK or CE.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight sets; no OUT_VALID SHALL appear for sets accepted before reset.
REQ-027 After RST deasserts, the first set accepted with IN_VALID=1, CE=1 SHALL emerge LOG2N CE-enabled cycles later.
REQ-028 Initial blocks SHALL NOT be used for state initialisation; reset is the only initialisation mechanism.

Verification
REQ-029 Basic sum (defaults): WORDS={4,-3,2,1} (word0=1), IN_VALID=1, CE=1 -> 2 cycles later RES=4, OUT_VALID=1, OVF=0.
REQ-030 Full precision (defaults): all four words = 16777215 -> RES=67108860 (27-bit), OVF=0; all words = -16777216 -> RES=-67108864.
REQ-031 Saturation (SATURATE=1, WIDTH=25, N_WORDS=4): all words = 16777215 -> RES=16777215, OVF=1; all words = -16777216 -> RES=-16777216, OVF=1; words {10,-5,3,1} -> RES=9, OVF=0.
REQ-032 Streaming and stall: 5 back-to-back sets with CE=1, then CE=0 for 3 cycles mid-stream -> outputs frozen during the stall, all 5 results in order, OUT_VALID gaps only from the stall.
REQ-033 Reset mid-flight: accept 2 sets, assert RST asynchronously between clock edges -> RES=0, OUT_VALID=0 immediately; neither set ever appears.
REQ-034 Depth sweep: N_WORDS=8 and 16 with WORDS=i+1 for word i -> RES=36 after 3 cycles and RES=136 after 4 cycles.
